jtag_cfg_bank: RTL
==================

// Module: jtag_cfg_bank
// PURPOSE
//  Parametrised JTAG target with an oversampled TAP, an addressed configuration bank and a status bank, all in a single clk domain.
//  Replaces the flat per-field scan chain with indexed REG_W-wide registers (N_CFG read/write, N_STAT read-only) plus an auto-incrementing address.
//  Sits between the pad-level JTAG interface and the analog/digital/CDR debug interfaces.
//  Drives cfg_q fields into those interfaces and samples their status words.
// PARAMETERS
//  IR_W        5              instruction register width (>=3)
//  REG_W       32             width of every cfg/stat register and of the CFG_RW/STAT_RD data registers
//  N_CFG       16             number of read/write configuration registers (>=1)
//  N_STAT      8              number of read-only status registers (>=1)
//  SYNC_STAGES 2              synchroniser depth on tck/tms/tdi/trst_n (>=2)
//  IDCODE      32'h1000_0001  IDCODE value; bit0 must be 1
//  CFG_RST     '0             packed N_CFG*REG_W reset image of cfg_q
//  ADDR_W (localparam) = $clog2(max(N_CFG,N_STAT)), min 1
// PORTS
//  clk          in   1              system clock; must run >= 4x tck frequency
//  rst          in   1              asynchronous, active-high reset
//  tck          in   1              JTAG clock, asynchronous, oversampled
//  tms          in   1              JTAG mode select
//  tdi          in   1              JTAG data in
//  trst_n       in   1              JTAG reset, active-low, synchronised
//  tdo          out  1              JTAG data out
//  tdo_en       out  1              high only in Shift-IR/Shift-DR
//  cfg_q        out  N_CFG*REG_W    configuration registers; reg i = cfg_q[i*REG_W +: REG_W]
//  cfg_upd      out  N_CFG          one-clk pulse on reg i the cycle it is written
//  stat_d       in   N_STAT*REG_W   status words; sampled at Capture-DR only
//  stat_cap     out  1              one-clk pulse when a status word is captured
// BEHAVIOUR
//  - Reset (rst): TAP=Test-Logic-Reset; IR=IDCODE; addr=0; auto_inc=0; addr_err=0; cfg_q=CFG_RST; tdo=0; tdo_en=0; cfg_upd=0; stat_cap=0.
//  - Sync: tck, tms, tdi and trst_n each pass through SYNC_STAGES flops.
//    tck_rise/tck_fall are one-clk pulses from the last stage vs. a delayed copy.
//  - TAP: standard IEEE 1149.1 16-state FSM; advances only on tck_rise using synchronised tms.
//    Synchronised trst_n=0 forces Test-Logic-Reset (same state as rst, but cfg_q is retained).
//    5 tck_rise with tms=1 reach Test-Logic-Reset from any state.
//  - Shifting: shift register loads at Capture-xR on tck_rise; shifts LSB-first on tck_rise in Shift-xR (tdi enters at MSB).
//    tdo/tdo_en update on tck_fall from the shift LSB. Latency tdi->tdo is DR length in tck cycles (BYPASS: 1).
//  - IR capture value = {'0, addr_err, 2'b01}. Update-IR loads IR; on Update-IR, addr_err clears.
//  - Opcodes: IDCODE=1 (32b, capture IDCODE); SEL_ADDR=2 ((ADDR_W+1)b {auto_inc,addr}); CFG_RW=3 (REG_W); STAT_RD=4 (REG_W).
//    All-ones and every undefined code select BYPASS (1b, capture 0).
//  - CFG_RW: Capture loads cfg[addr]. Update-DR writes cfg[addr] and pulses cfg_upd[addr] one clk later.
//  - STAT_RD: Capture loads stat[addr] and pulses stat_cap. Update-DR does not write.
//  - Out-of-range addr (>= N_CFG for CFG_RW, >= N_STAT for STAT_RD): capture returns 0, update is ignored, addr_err is set (sticky).
//  - Auto-increment: if auto_inc=1, every Update-DR of CFG_RW/STAT_RD then sets addr += 1, wrapping to 0 past that bank's last index.
//    Out-of-range addr also wraps to 0.
//  - SEL_ADDR Update-DR sets addr/auto_inc and does not increment.
//  - rst asserted mid-shift aborts the shift with no cfg write; shift contents are discarded.
//  - tck_rise and tck_fall never occur in the same clk, which the >=4x ratio guarantees.
// STRUCTURE
//  - Package jtag_cfg_pkg holds:
//    - tap_state_t enum (16 states);
//    - opcode localparams (OP_IDCODE, OP_SEL_ADDR, OP_CFG_RW, OP_STAT_RD, OP_BYPASS);
//    - a function next_tap_state(state, tms).
//  - Sub-module jtag_tap_fsm: sync, edge detect, TAP state and decoded capture/shift/update strobes.
//    The top level holds IR, the DRs, addr and the banks.
// TESTING
//  1. After rst, 32 tck in Shift-DR -> tdo stream equals IDCODE LSB-first; IR capture reads 5'b00001.
//  2. BYPASS (IR=5'h1F): shift 8'hA5 -> tdo returns A5 delayed by one tck; cfg_q is unchanged.
//  3. SEL_ADDR {0,4'd3}, then CFG_RW shift 32'hDEAD_BEEF -> cfg reg3=DEADBEEF; cfg_upd=4'b1000-bit pulse for one clk; a re-capture reads DEADBEEF.
//  4. SEL_ADDR {1,4'd14}, then 3 CFG_RW writes 1,2,3 -> regs 14=1, 15=2, 0=3 (wrap).
//  5. STAT_RD at addr 9 with N_STAT=8 -> capture 0; next IR capture shows addr_err=1 (value 5'b00101).
//  6. trst_n low mid-Shift-DR of CFG_RW -> TAP=TLR, IR=IDCODE, no write; rst pulse -> cfg_q=CFG_RST.

Source files
------------

// File: rtl/jtag_cfg_pkg.sv
// Shared types, opcodes and TAP next-state logic for the JTAG configuration bank.
package jtag_cfg_pkg;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    // Data register currently selected by the IR.
    typedef enum logic [2:0] {DR_BYP, DR_ID, DR_ADDR, DR_CFG, DR_STAT} dr_sel_t;

    localparam int unsigned OP_IDCODE   = 1;
    localparam int unsigned OP_SEL_ADDR = 2;
    localparam int unsigned OP_CFG_RW   = 3;
    localparam int unsigned OP_STAT_RD  = 4;
    localparam int unsigned OP_BYPASS   = 32'hFFFF_FFFF;  // truncated to IR_W -> all ones

    function automatic tap_state_t next_tap_state(input tap_state_t s, input logic tms);
        case (s)
            TLR:      return tms ? TLR    : RTI;
            RTI:      return tms ? SEL_DR : RTI;
            SEL_DR:   return tms ? SEL_IR : CAP_DR;
            CAP_DR:   return tms ? EX1_DR : SHIFT_DR;
            SHIFT_DR: return tms ? EX1_DR : SHIFT_DR;
            EX1_DR:   return tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: return tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   return tms ? UPD_DR : SHIFT_DR;
            UPD_DR:   return tms ? SEL_DR : RTI;
            SEL_IR:   return tms ? TLR    : CAP_IR;
            CAP_IR:   return tms ? EX1_IR : SHIFT_IR;
            SHIFT_IR: return tms ? EX1_IR : SHIFT_IR;
            EX1_IR:   return tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: return tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   return tms ? UPD_IR : SHIFT_IR;
            UPD_IR:   return tms ? SEL_DR : RTI;
            default:  return TLR;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// Oversampled TAP: synchronises the pad signals into clk, detects tck edges,
// runs the 16-state controller and decodes capture/shift/update strobes.
module jtag_tap_fsm
    import jtag_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    input  logic       trst_n,
    output tap_state_t state,
    output logic       tck_fall,
    output logic       tdi_s,
    output logic       trst_s,
    output logic       cap_dr,
    output logic       sh_dr,
    output logic       upd_dr,
    output logic       cap_ir,
    output logic       sh_ir,
    output logic       upd_ir
);

    localparam int L = SYNC_STAGES - 1;

    logic [L:0] tck_sy, tms_sy, tdi_sy, trstn_sy;
    logic       tck_d;
    logic       tck_rise;
    tap_state_t state_nx;

    // Synchroniser chains; all four share the same depth so tms/tdi stay aligned with tck.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_sy   <= '0;
            tms_sy   <= '0;
            tdi_sy   <= '0;
            trstn_sy <= '0;
            tck_d    <= 1'b0;
        end else begin
            tck_sy   <= {tck_sy[L-1:0], tck};
            tms_sy   <= {tms_sy[L-1:0], tms};
            tdi_sy   <= {tdi_sy[L-1:0], tdi};
            trstn_sy <= {trstn_sy[L-1:0], trst_n};
            tck_d    <= tck_sy[L];
        end
    end

    assign tck_rise = tck_sy[L] & ~tck_d;
    assign tck_fall = ~tck_sy[L] & tck_d;
    assign tdi_s    = tdi_sy[L];
    assign trst_s   = ~trstn_sy[L];

    // TAP state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TLR;
        else     state <= state_nx;
    end

    // Next state and strobes; strobes fire on the edge that acts on the current state.
    always_comb begin
        state_nx = state;
        if (trst_s)        state_nx = TLR;
        else if (tck_rise) state_nx = next_tap_state(state, tms_sy[L]);
        cap_dr = !trst_s && tck_rise && (state == CAP_DR);
        sh_dr  = !trst_s && tck_rise && (state == SHIFT_DR);
        cap_ir = !trst_s && tck_rise && (state == CAP_IR);
        sh_ir  = !trst_s && tck_rise && (state == SHIFT_IR);
        upd_dr = !trst_s && tck_fall && (state == UPD_DR);
        upd_ir = !trst_s && tck_fall && (state == UPD_IR);
    end

endmodule

// File: rtl/jtag_cfg_bank.sv
// JTAG target with an addressed read/write configuration bank and a read-only
// status bank. Holds IR, data shift register, address pointer and the banks.
module jtag_cfg_bank
    import jtag_cfg_pkg::*;
#(
    parameter int                     IR_W        = 5,
    parameter int                     REG_W       = 32,
    parameter int                     N_CFG       = 16,
    parameter int                     N_STAT      = 8,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [31:0]            IDCODE      = 32'h1000_0001,
    parameter logic [N_CFG*REG_W-1:0] CFG_RST     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tck,
    input  logic                      tms,
    input  logic                      tdi,
    input  logic                      trst_n,
    output logic                      tdo,
    output logic                      tdo_en,
    output logic [N_CFG*REG_W-1:0]    cfg_q,
    output logic [N_CFG-1:0]          cfg_upd,
    input  logic [N_STAT*REG_W-1:0]   stat_d,
    output logic                      stat_cap
);

    localparam int AMAX   = (N_CFG > N_STAT) ? N_CFG : N_STAT;
    localparam int ADDR_W = (AMAX > 1) ? $clog2(AMAX) : 1;
    localparam int DR_W   = (REG_W > 32) ? REG_W : 32;
    localparam int LEN_W  = $clog2(DR_W + 1);

    tap_state_t        state;
    logic              tck_fall, tdi_s, trst_s;
    logic              cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

    logic [IR_W-1:0]   ir, ir_sh;
    logic [DR_W-1:0]   dr_sh, dr_nx, cap_val;
    logic [LEN_W-1:0]  dr_len;
    dr_sel_t           dr_sel;
    logic [ADDR_W-1:0] addr, addr_inc, cidx, sidx;
    logic              auto_inc, addr_err;
    logic              cfg_ok, stat_ok;
    int                bank_last;

    logic [REG_W-1:0]  cfg_r  [N_CFG];
    logic [REG_W-1:0]  stat_w [N_STAT];

    jtag_tap_fsm #(.SYNC_STAGES(SYNC_STAGES)) u_tap (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .trst_n(trst_n),
        .state(state), .tck_fall(tck_fall), .tdi_s(tdi_s), .trst_s(trst_s),
        .cap_dr(cap_dr), .sh_dr(sh_dr), .upd_dr(upd_dr),
        .cap_ir(cap_ir), .sh_ir(sh_ir), .upd_ir(upd_ir)
    );

    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
        assign cfg_q[g*REG_W +: REG_W] = cfg_r[g];
    end
    for (genvar g = 0; g < N_STAT; g++) begin : g_stat
        assign stat_w[g] = stat_d[g*REG_W +: REG_W];
    end

    // Range checks; clamped indices keep out-of-range addresses off the arrays.
    assign cfg_ok  = int'(addr) < N_CFG;
    assign stat_ok = int'(addr) < N_STAT;
    assign cidx    = cfg_ok  ? addr : '0;
    assign sidx    = stat_ok ? addr : '0;

    // IR decode to DR select; anything not recognised is BYPASS.
    always_comb begin
        dr_sel = DR_BYP;
        case (ir)
            IR_W'(OP_IDCODE):   dr_sel = DR_ID;
            IR_W'(OP_SEL_ADDR): dr_sel = DR_ADDR;
            IR_W'(OP_CFG_RW):   dr_sel = DR_CFG;
            IR_W'(OP_STAT_RD):  dr_sel = DR_STAT;
            IR_W'(OP_BYPASS):   dr_sel = DR_BYP;
            default:            dr_sel = DR_BYP;
        endcase
    end

    // DR length and capture value, plus next shift value with tdi entering at the active MSB.
    always_comb begin
        dr_len  = LEN_W'(1);
        cap_val = '0;
        case (dr_sel)
            DR_ID:   begin dr_len = LEN_W'(32);       cap_val = DR_W'(IDCODE); end
            DR_ADDR: begin dr_len = LEN_W'(ADDR_W+1); cap_val = DR_W'({auto_inc, addr}); end
            DR_CFG:  begin dr_len = LEN_W'(REG_W);    cap_val = cfg_ok  ? DR_W'(cfg_r[cidx])  : '0; end
            DR_STAT: begin dr_len = LEN_W'(REG_W);    cap_val = stat_ok ? DR_W'(stat_w[sidx]) : '0; end
            default: begin dr_len = LEN_W'(1);        cap_val = '0; end
        endcase
        dr_nx = dr_sh >> 1;
        for (int i = 0; i < DR_W; i++)
            if (i == int'(dr_len) - 1) dr_nx[i] = tdi_s;
    end

    // Auto-increment target, wrapping past the active bank's last index.
    always_comb begin
        bank_last = (dr_sel == DR_CFG) ? N_CFG - 1 : N_STAT - 1;
        addr_inc  = (int'(addr) >= bank_last) ? '0 : addr + ADDR_W'(1);
    end

    // Instruction register path; Test-Logic-Reset forces IDCODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir    <= IR_W'(OP_IDCODE);
            ir_sh <= '0;
        end else if (trst_s || state == TLR) begin
            ir    <= IR_W'(OP_IDCODE);
        end else if (cap_ir) begin
            ir_sh <= IR_W'({addr_err, 2'b01});
        end else if (sh_ir) begin
            ir_sh <= {tdi_s, ir_sh[IR_W-1:1]};
        end else if (upd_ir) begin
            ir    <= ir_sh;
        end
    end

    // Data shift register; cleared on reset so an aborted shift leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         dr_sh <= '0;
        else if (cap_dr) dr_sh <= cap_val;
        else if (sh_dr)  dr_sh <= dr_nx;
    end

    // Address pointer, auto-increment flag and sticky out-of-range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr     <= '0;
            auto_inc <= 1'b0;
            addr_err <= 1'b0;
        end else if (trst_s) begin
            addr     <= '0;
            auto_inc <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (cap_dr && ((dr_sel == DR_CFG && !cfg_ok) || (dr_sel == DR_STAT && !stat_ok)))
                addr_err <= 1'b1;
            if (upd_ir)
                addr_err <= 1'b0;
            if (upd_dr) begin
                if (dr_sel == DR_ADDR)
                    {auto_inc, addr} <= dr_sh[ADDR_W:0];
                else if ((dr_sel == DR_CFG || dr_sel == DR_STAT) && auto_inc)
                    addr <= addr_inc;
            end
        end
    end

    // Configuration bank write and one-clk update strobe; TAP reset keeps contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CFG; i++) cfg_r[i] <= CFG_RST[i*REG_W +: REG_W];
            cfg_upd <= '0;
        end else begin
            for (int i = 0; i < N_CFG; i++)
                cfg_upd[i] <= upd_dr && dr_sel == DR_CFG && cfg_ok && i == int'(cidx);
            if (upd_dr && dr_sel == DR_CFG && cfg_ok)
                cfg_r[cidx] <= dr_sh[REG_W-1:0];
        end
    end

    // Status capture strobe, only for in-range captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stat_cap <= 1'b0;
        else     stat_cap <= cap_dr && dr_sel == DR_STAT && stat_ok;
    end

    // tdo/tdo_en launch on tck falling edge from the active shift register LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (trst_s) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (tck_fall) begin
            tdo_en <= (state == SHIFT_IR) || (state == SHIFT_DR);
            tdo    <= (state == SHIFT_IR) ? ir_sh[0] :
                      (state == SHIFT_DR) ? dr_sh[0] : 1'b0;
        end
    end

endmodule
